// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: valid/ready write port carrying one payload word
interface uart_tx_buffered_if #(parameter int DATA_BITS = 8);
  logic data_valid;
  logic [DATA_BITS-1:0] data_in;
  logic ready;
  modport master (output data_valid, data_in, input ready);
  modport slave (input data_valid, data_in, output ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO whose read side never sees a same-edge write
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == FULL_COUNT;
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // storage array, written only on accepted pushes
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-fed UART transmitter with configurable frame format
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS = 8,
  parameter parity_t PARITY = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  uart_tx_buffered_if.slave wr,
  output logic tx_serial,
  output logic tx_active,
  output logic tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic overflow
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT-1);
  localparam logic [IW-1:0] D_LAST = IW'(DATA_BITS-1);
  localparam logic [IW-1:0] S_LAST = IW'(STOP_BITS-1);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n, dout;
  logic par, par_n, pop, done_n, tx_n, full, empty, bit_end, last_data, last_stop;
  assign wr.ready = !full;
  assign bit_end = cnt == C_LAST;
  assign last_data = idx == D_LAST;
  assign last_stop = idx == S_LAST;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(wr.data_valid), .pop(pop), .din(wr.data_in),
    .dout(dout), .full(full), .empty(empty), .count(fifo_count)
  );
  // FSM register plus all registered outputs, so every output is glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      par <= par_n;
      tx_serial <= tx_n;
      tx_active <= state_n != IDLE;
      tx_done <= done_n;
      overflow <= overflow | (wr.data_valid && !wr.ready);
    end
  end
  // next state, bit timing, shifting, parity accumulation and the next line level
  always_comb begin
    state_n = state;
    cnt_n = bit_end ? '0 : cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    par_n = par;
    done_n = 1'b0;
    case (state)
      IDLE: cnt_n = '0;
      START: state_n = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        sh_n = sh >> 1;
        par_n = par ^ sh[0];
        idx_n = last_data ? '0 : idx + 1'b1;
        if (last_data) state_n = PARITY == PAR_NONE ? STOP : uart_pkg::PARITY;
      end
      uart_pkg::PARITY: state_n = bit_end ? STOP : uart_pkg::PARITY;
      STOP: if (bit_end) begin
        idx_n = last_stop ? '0 : idx + 1'b1;
        done_n = last_stop;
        if (last_stop) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    pop = !empty && (state == IDLE || (state == STOP && bit_end && last_stop));
    if (pop) begin
      state_n = START;
      sh_n = dout;
      par_n = 1'b0;
    end
    tx_n = state_n == START ? 1'b0 :
           state_n == DATA ? sh_n[0] :
           state_n == uart_pkg::PARITY ? par_n ^ (PARITY == PAR_ODD) : 1'b1;
  end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised, buffered UART transmitter that supersedes the fixed 8N1 `UART_TX`. It accepts words through a valid/ready write port into an internal FIFO and serialises them back-to-back onto `tx_serial`. Data width, parity, stop-bit count, baud divisor and buffer depth are all configurable. It sits between the filter result path in `top_level` and the external UART line, so a whole result block can be queued without per-byte handshaking.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit; 868 gives 115200 baud at 100 MHz; minimum 2.
- `DATA_BITS`, 8, payload bits per frame; legal range 5–9.
- `PARITY`, `PAR_NONE`, one of `PAR_NONE`, `PAR_EVEN` or `PAR_ODD` (`uart_pkg::parity_t`).
- `STOP_BITS`, 1, number of stop bits; 1 or 2.
- `FIFO_DEPTH`, 16, buffer entries; power of two, at least 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_valid`  in  1  write request.
- `data_in`  in  DATA_BITS  word to send, LSB transmitted first.
- `ready`  out  1  FIFO not full; a write is accepted when `data_valid && ready`.
- `tx_serial`  out  1  UART line; idles high.
- `tx_active`  out  1  high while a frame is on the line.
- `tx_done`  out  1  one-cycle pulse at the end of each frame.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of occupied entries.
- `overflow`  out  1  sticky; set by a write attempted while `!ready`.

## Operation
- Frame format: start bit (0), then DATA_BITS data bits LSB first, then an optional parity bit, then STOP_BITS stop bits (1).
- Every bit lasts exactly CLKS_PER_BIT cycles.
- Parity: `PAR_EVEN` sends the XOR of the data bits; `PAR_ODD` sends its inverse.
- FSM states and transitions:
  - `IDLE` → `START` when the FIFO is not empty.
  - `START` → `DATA`.
  - `DATA` → `PARITY` after bit DATA_BITS-1, or → `STOP` when PARITY is `PAR_NONE`.
  - `PARITY` → `STOP`.
  - `STOP` → `IDLE`, or directly → `START` when the FIFO is not empty.
- Pop: the FSM pops the FIFO head into a shift register on the edge it enters `START`.
- Back-to-back frames: no idle cycles are inserted between consecutive frames while the FIFO holds data.
- Full FIFO: a write while full is dropped and sets `overflow`. FIFO contents are unaffected.
- Simultaneous push and pop on one edge:
  - The FIFO has no bypass: an item pushed on an edge is not visible to a pop on the same edge.
  - `fifo_count` stays unchanged.
  - `ready` is computed from the registered count, so a full FIFO does not accept a write even on the pop edge.
- `overflow` is cleared only by `rst`.
- Counters: the bit-time counter is $clog2(CLKS_PER_BIT) bits wide and the bit-index counter is $clog2(DATA_BITS) bits wide. Both wrap to 0 on each bit/state change and never overflow.

## Timing
- Reset values: `tx_serial`=1, `tx_active`=0, `tx_done`=0, `ready`=1, `fifo_count`=0, `overflow`=0, FSM in `IDLE`, FIFO empty.
- Reset mid-frame: the frame is aborted and the queue discarded. `tx_serial` is 1 from the first edge with `rst` high. No `tx_done` is produced.
- Start latency:
  - Write accepted at edge N into an empty FIFO with the FSM idle.
  - `fifo_count`=1 after edge N.
  - Pop at edge N+1; `tx_serial`=0 and `tx_active`=1 after edge N+1.
- Frame length: (1 + DATA_BITS + (PARITY≠NONE) + STOP_BITS) × CLKS_PER_BIT cycles, from the edge entering `START` to the edge leaving `STOP`.
- `tx_done` is high for the single cycle following the edge that leaves `STOP`.
- `tx_active` falls on that same edge only when the next state is `IDLE`; during back-to-back frames it stays high.
- All outputs are registered. No combinational path exists from `data_valid` to any output.

## Structure
- Package `uart_pkg` holds:
  - `parity_t` enum (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - `tx_state_t` enum (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`);
  - constant `DEFAULT_CLKS_PER_BIT` = 868.
- Sub-module `sync_fifo`, parametrised by WIDTH and DEPTH. It provides push, pop, dout, full, empty and count.
- Top module: FSM, bit-time counter, shift register, parity accumulator and overflow flag.

## Test plan
- Single word, defaults: write 0xA5.
  - `tx_serial` sequence is 0,1,0,1,0,0,1,0,1,1, each bit 868 cycles.
  - One `tx_done` pulse, 8680 cycles after the start bit begins.
- DATA_BITS=7, PARITY=`PAR_EVEN`, STOP_BITS=2, CLKS_PER_BIT=4: write 0x55.
  - Frame is 0, 1010101, parity 0, 1, 1; total 44 cycles.
- Back-to-back with defaults: write 0x01, 0x02, 0x03 on consecutive cycles.
  - 30 contiguous bit-times with no idle gap.
  - Exactly three `tx_done` pulses; `tx_active` stays high throughout.
- Overflow with FIFO_DEPTH=4: push 6 words while the first frame transmits.
  - `ready` drops at count 4; the 6th write is dropped and `overflow`=1.
  - The first 5 words are transmitted in order.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 3.
  - `tx_serial`=1, `fifo_count`=0 and no `tx_done` on the following edge.
  - A subsequent write of 0x3C transmits correctly.
- Simultaneous push and pop: write a word on the exact edge a frame's `STOP` state ends while 1 word is queued.
  - `fifo_count` stays at 1; both words are sent in order.
